fpadd_arbiter: RTL and testbench
================================

// Module: fpadd_arbiter
// PURPOSE
//  Shares one pipelined FP adder (FADD/FSUB/FLT/FLOOR, run/stall protocol) between two requesters.
//  - Arbitrates requests and latches the winner's operands.
//  - Sequences run/stall and captures the result.
//  - Returns the result with a one-cycle done pulse; aborts with an error after a stall timeout.
//  Sits between the CPU FP issue path (port 0) and a secondary FP client (port 1).
// PARAMETERS
//  TIMEOUT  15  max RUN cycles with fa_stall high before abort (1..255)
// PORTS
//  clk       in   1   single clock, rising edge
//  rst       in   1   asynchronous, active-high reset
//  req0/req1 in   1   request; held high until matching done, operands stable meanwhile
//  u0/u1     in   1   FLT select for that requester's op
//  v0/v1     in   1   FLOOR select for that requester's op
//  x0/x1     in   32  operand x
//  y0/y1     in   32  operand y
//  done0/1   out  1   one-cycle pulse: result valid on z
//  err       out  1   with done: op aborted by timeout, z=0
//  z         out  32  result register, valid in done cycle, held until next capture
//  busy      out  1   state != IDLE
//  fa_run    out  1   adder run
//  fa_u/fa_v out  1   latched op select to adder
//  fa_x/fa_y out  32  latched operands to adder
//  fa_stall  in   1   adder stall
//  fa_z      in   32  adder result
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, operand/result regs 0, last-grant = 1 (port 0 wins first).
//  States:
//  - IDLE: if any req, grant one (see arbitration), latch u,v,x,y, clear cnt -> RUN; else stay.
//  - RUN: fa_run=1, cnt+=1 per cycle.
//    - fa_stall=0 -> z<=fa_z, err<=0 -> DONE.
//    - Else if cnt==TIMEOUT -> z<=0, err<=1 -> DONE.
//  - DONE: fa_run=0, so the adder's internal state is cleared at the next edge; done<grant>=1.
//    - Served requester's req is ignored this cycle.
//    - If the other req is high: grant it, latch operands -> RUN.
//    - Else -> IDLE.
//  Latency with a 3-stall-cycle adder: req sampled at edge 0 -> RUN; fa_stall drops after edge 3;
//  capture at edge 4; done high in the cycle after edge 4.
//  Back-to-back throughput: one op per 5 cycles.
//  fa_run is never high in two consecutive ops without an intervening low cycle.
//  done0 and done1 are never high together. err is high only together with a done.
//  A req dropped mid-operation does not abort the op; the op completes, done is still pulsed,
//  and the requester ignores it.
//  cnt is 8 bits; no wrap, because RUN exits at TIMEOUT.
//  Reset asserted in RUN or DONE: immediate return to IDLE, fa_run=0, no done pulse.
// CONFIGURATION
//  FPARB_ROUND_ROBIN_EN defined: when both requests contend, grant the port not granted last.
//  FPARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 always wins. last-grant is unused.
// TESTING
//  1. req0, u0=v0=0, x0=3F800000, y0=40000000
//     -> done0 in cycle after edge 4, z=40400000, err=0, busy 0 after.
//  2. req1, u1=1 (FLT), x1=00000005
//     -> done1, z=40A00000; fa_u=1 throughout RUN.
//  3. req0 and req1 high in the same cycle, both held, all ops 1.0+1.0
//     - RR build: grants alternate 0,1,0,1 and each done is 5 cycles apart.
//     - Fixed-priority build: port 0 is granted every time port 0 re-requests.
//  4. Adder model with fa_stall stuck high, req0
//     -> exactly TIMEOUT RUN cycles, then done0=1, err=1, z=0; next op completes normally.
//  5. rst pulsed during the 2nd RUN cycle
//     -> fa_run, busy, z = 0 immediately; no done; next req0 gives correct result at normal latency.
//  6. req0 v0=1 (FLOOR), x0=40A00000 (5.0) -> done0 with z = adder FLOOR output, passed unchanged.

Source files
------------

// File: rtl/fpadd_arbiter.sv
// Two-port arbiter sharing one pipelined FP adder with run/stall sequencing and stall timeout.
// Optional FPARB_ROUND_ROBIN_EN: alternate grants on contention (else port 0 has priority).
module fpadd_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        u0,
    input  logic        u1,
    input  logic        v0,
    input  logic        v1,
    input  logic [31:0] x0,
    input  logic [31:0] x1,
    input  logic [31:0] y0,
    input  logic [31:0] y1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic [31:0] z,
    output logic        busy,
    output logic        fa_run,
    output logic        fa_u,
    output logic        fa_v,
    output logic [31:0] fa_x,
    output logic [31:0] fa_y,
    input  logic        fa_stall,
    input  logic [31:0] fa_z
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] TO8 = 8'(TIMEOUT);

    state_t      state, state_n;
    logic        gnt, gnt_n;
    logic        lat;
    logic        cap_ok;
    logic        cap_to;
    logic        err_q;
    logic        other;
    logic        pick;
    logic [7:0]  cnt;
    logic [7:0]  cnt_inc;

    assign cnt_inc = cnt + 8'd1;

`ifdef FPARB_ROUND_ROBIN_EN
    logic last;

    assign pick = (req0 && req1) ? ~last : ~req0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (lat) begin
            last <= gnt_n;
        end
    end
`else
    assign pick = ~req0;
`endif

    assign other = gnt ? req0 : req1;

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        lat     = 1'b0;
        cap_ok  = 1'b0;
        cap_to  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    lat     = 1'b1;
                    gnt_n   = pick;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (!fa_stall) begin
                    cap_ok  = 1'b1;
                    state_n = DONE;
                end else if (cnt_inc == TO8) begin
                    cap_to  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                // The requester just served is ignored; only the other port can chain.
                if (other) begin
                    lat     = 1'b1;
                    gnt_n   = ~gnt;
                    state_n = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 1'b0;
            cnt   <= 8'd0;
            fa_u  <= 1'b0;
            fa_v  <= 1'b0;
            fa_x  <= 32'd0;
            fa_y  <= 32'd0;
            z     <= 32'd0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            if (lat) begin
                cnt  <= 8'd0;
                fa_u <= gnt_n ? u1 : u0;
                fa_v <= gnt_n ? v1 : v0;
                fa_x <= gnt_n ? x1 : x0;
                fa_y <= gnt_n ? y1 : y0;
            end else if (state == RUN) begin
                cnt <= cnt_inc;
            end
            if (cap_ok) begin
                z     <= fa_z;
                err_q <= 1'b0;
            end else if (cap_to) begin
                z     <= 32'd0;
                err_q <= 1'b1;
            end
        end
    end

    assign busy   = (state != IDLE);
    assign fa_run = (state == RUN);
    assign done0  = (state == DONE) && !gnt;
    assign done1  = (state == DONE) && gnt;
    assign err    = err_q && (state == DONE);

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Self-checking bench for fpadd_arbiter: vector table, contention/reset sequences,
// and randomized two-port traffic against a stall-programmable adder model.
module tb_fpadd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, u0, u1, v0, v1;
    logic [31:0] x0, x1, y0, y1;
    logic        done0, done1, err, busy;
    logic [31:0] z;
    logic        fa_run, fa_u, fa_v, fa_stall;
    logic [31:0] fa_x, fa_y, fa_z;

    int vectors = 0;
    int miscompares = 0;
    int viol = 0;
    int rc = 0;
    int cur_s = 0;
    int set_s = 0;
    logic rnd_en = 1'b0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    fpadd_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .u0(u0), .u1(u1), .v0(v0), .v1(v1),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .done0(done0), .done1(done1), .err(err), .z(z), .busy(busy),
        .fa_run(fa_run), .fa_u(fa_u), .fa_v(fa_v),
        .fa_x(fa_x), .fa_y(fa_y),
        .fa_stall(fa_stall), .fa_z(fa_z)
    );

    // Behavioural adder: known answers for the named cases, a fixed mock otherwise.
    function automatic logic [31:0] fmodel(logic u, logic v, logic [31:0] x, logic [31:0] y);
        if (!u && !v && x == 32'h3F800000 && y == 32'h40000000) return 32'h40400000;
        if (!u && !v && x == 32'h3F800000 && y == 32'h3F800000) return 32'h40000000;
        if (v && x == 32'h40A00000) return 32'h40A00000;
        if (u && !v && x == 32'h00000005) return 32'h40A00000;
        if (v) return {x[31:16], 16'h0};
        if (u) return {1'b0, x[30:0]} ^ 32'h4B000000;
        return x ^ {y[15:0], y[31:16]};
    endfunction

    assign fa_z = fmodel(fa_u, fa_v, fa_x, fa_y);
    assign fa_stall = fa_run && (cur_s == 255 || rc < cur_s);

    always @(posedge clk) begin
        if (fa_run) begin
            rc <= rc + 1;
        end else begin
            rc <= 0;
            cur_s <= rnd_en ? int'($urandom_range(0, 5)) : set_s;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (done0 && done1) viol <= viol + 1;
            if (err && !(done0 || done1)) viol <= viol + 1;
            if ((done0 || done1) && fa_run) viol <= viol + 1;
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", nm, got, exp);
        end
    endtask

    typedef struct {
        int          port;
        logic        u;
        logic        v;
        logic [31:0] x;
        logic [31:0] y;
        int          s;
        logic [31:0] ez;
        logic        eerr;
        int          elat;
    } vec_t;

    vec_t tab[6];

    task automatic drive(int p, logic u, logic v, logic [31:0] x, logic [31:0] y);
        if (p == 0) begin
            u0 = u; v0 = v; x0 = x; y0 = y; req0 = 1'b1;
        end else begin
            u1 = u; v1 = v; x1 = x; y1 = y; req1 = 1'b1;
        end
    endtask

    task automatic apply_vec(vec_t t);
        int lat = 0;
        int runs = 0;
        int opbad = 0;
        int got;
        set_s = t.s;
        drive(t.port, t.u, t.v, t.x, t.y);
        while (!(done0 || done1) && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (fa_run) begin
                runs++;
                if ({fa_u, fa_v, fa_x, fa_y} !== {t.u, t.v, t.x, t.y}) opbad++;
            end
        end
        got = done1 ? 1 : (done0 ? 0 : -1);
        chk("done_port", got, t.port);
        chk("z", z, t.ez);
        chk("err", {31'd0, err}, {31'd0, t.eerr});
        chk("latency", lat, t.elat);
        chk("run_cycles", runs, t.elat - 1);
        chk("run_operands", opbad, 0);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        chk("busy_after", {31'd0, busy}, 0);
    endtask

    task automatic rq(int p);
        logic u, v;
        logic [31:0] x, y;
        int k;
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            u = 1'($urandom_range(0, 1));
            v = 1'($urandom_range(0, 1));
            x = $urandom;
            y = $urandom;
            drive(p, u, v, x, y);
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!(p == 0 ? done0 : done1) && k < 40);
            chk("rnd_wait_bound", {31'd0, k <= 16}, 1);
            chk("rnd_z", z, fmodel(u, v, x, y));
            chk("rnd_err", {31'd0, err}, 0);
            if (p == 0) req0 = 1'b0;
            else req1 = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dport[4];
        int dcyc[4];
        int nd, cyc, k, expf;
        tab[0] = '{0, 1'b0, 1'b0, 32'h3F800000, 32'h40000000, 3, 32'h40400000, 1'b0, 5};
        tab[1] = '{1, 1'b1, 1'b0, 32'h00000005, 32'h00000000, 3, 32'h40A00000, 1'b0, 5};
        tab[2] = '{0, 1'b0, 1'b1, 32'h40A00000, 32'h00000000, 2, 32'h40A00000, 1'b0, 4};
        tab[3] = '{0, 1'b0, 1'b0, 32'h3F800000, 32'h3F800000, 255, 32'h00000000, 1'b1, 16};
        tab[4] = '{0, 1'b0, 1'b0, 32'h3F800000, 32'h40000000, 1, 32'h40400000, 1'b0, 3};
        tab[5] = '{1, 1'b0, 1'b0, 32'h3F800000, 32'h3F800000, 0, 32'h40000000, 1'b0, 2};

        rst = 1'b1;
        {req0, req1, u0, u1, v0, v1} = '0;
        {x0, x1, y0, y1} = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_ctl", {25'd0, done0, done1, err, busy, fa_run, fa_u, fa_v}, 0);
        chk("reset_z", z, 0);
        chk("reset_fa_x", fa_x, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) apply_vec(tab[i]);

        // Both ports held: grants alternate and completions are 5 cycles apart.
        set_s = 3;
        drive(0, 1'b0, 1'b0, 32'h3F800000, 32'h3F800000);
        drive(1, 1'b0, 1'b0, 32'h3F800000, 32'h3F800000);
        nd = 0;
        cyc = 0;
        while (nd < 4 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (done0 || done1) begin
                dport[nd] = done1 ? 1 : 0;
                dcyc[nd] = cyc;
                chk("contend_z", z, 32'h40000000);
                nd++;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("contend_count", nd, 4);
        for (int i = 0; i < 4; i++) chk("contend_port", dport[i], i % 2);
        for (int i = 1; i < 4; i++) chk("contend_gap", dcyc[i] - dcyc[i-1], 5);
        @(negedge clk);
        chk("contend_idle", {31'd0, busy}, 0);

        // After a port 0 op, a simultaneous pair shows the arbitration policy.
        apply_vec(tab[5]);
        apply_vec(tab[0]);
`ifdef FPARB_ROUND_ROBIN_EN
        expf = 1;
`else
        expf = 0;
`endif
        set_s = 1;
        drive(0, 1'b0, 1'b0, 32'h3F800000, 32'h3F800000);
        drive(1, 1'b0, 1'b0, 32'h3F800000, 32'h3F800000);
        for (int j = 0; j < 2; j++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!(done0 || done1) && k < 40);
            chk("policy_port", done1 ? 1 : (done0 ? 0 : -1), j == 0 ? expf : 1 - expf);
            if (done0) req0 = 1'b0;
            if (done1) req1 = 1'b0;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);

        // Reset in the 2nd RUN cycle: immediate clear, no done, then a clean op.
        set_s = 3;
        drive(0, 1'b0, 1'b0, 32'h3F800000, 32'h40000000);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_run_fa_run", {31'd0, fa_run}, 0);
        chk("rst_run_busy", {31'd0, busy}, 0);
        chk("rst_run_z", z, 0);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (6) begin
            @(negedge clk);
            if (done0 || done1) nd++;
        end
        chk("rst_no_done", nd, 0);
        apply_vec(tab[0]);

        // Randomized two-port traffic.
        rnd_en = 1'b1;
        fork
            rq(0);
            rq(1);
        join
        repeat (3) @(negedge clk);
        chk("protocol_violations", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
